blit_wr_buf: RTL
================

// Module: blit_wr_buf
// PURPOSE
//  Blitter destination write stage, directly downstream of comp_ctrl.
//  - Combines comp_ctrl byte inhibits (dbinh_n, nowrite) with the edge byte mask into per-byte write enables.
//  - Queues each accepted phrase write in a small FIFO.
//  - Presents writes to the memory interface with a valid/ack handshake.
//  - Back-pressures the inner-loop state machine through wr_full.
// PARAMETERS
//  AW     21  phrase address width (24-bit byte address >> 3)
//  DEPTH  2   FIFO entries; power of two, >= 2
// PORTS
//  sys_clk    in   1   sole clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  wr_stb     in   1   one-cycle request to write the current phrase (from step_inner path)
//  waddr      in   AW  phrase address of the request
//  srcd       in   64  source/pattern data for the phrase
//  dstd       in   64  destination read data (used only with merge option)
//  emask      in   8   edge byte mask, 1 = byte inside window
//  dbinh_n    in   8   from comp_ctrl, 1 = byte may be written
//  nowrite    in   1   from comp_ctrl, 1 = suppress the whole phrase
//  wr_full    out  1   FIFO full; upstream must not assert wr_stb
//  wr_ovf     out  1   sticky: wr_stb arrived while full
//  mem_wr     out  1   write valid to memory interface
//  mem_addr   out  AW  head-entry address
//  mem_data   out  64  head-entry data
//  mem_be     out  8   head-entry byte enables, bit n = bits [8n+7:8n]
//  mem_ack    in   1   memory accepted head entry this cycle
// BEHAVIOUR
//  - Reset: FIFO empty (count=0); rd/wr pointers=0; mem_wr=0, wr_full=0, wr_ovf=0.
//    mem_addr/mem_data/mem_be=0 while empty. Reset overrides all inputs, including a pending mem_ack.
//  - be = dbinh_n & emask, computed combinationally at the strobe.
//  - Push: wr_stb & ~wr_full & ~nowrite & (be != 0).
//    Entry {waddr, data, be} is written at the wr pointer; the pointer wraps modulo DEPTH.
//  - Drop: wr_stb with nowrite=1, or with be==0.
//    No entry is created; no flag is raised; the strobe is consumed silently.
//  - Pop: mem_wr & mem_ack. The rd pointer advances and wraps modulo DEPTH.
//  - mem_wr = (count != 0).
//    The mem_* outputs always show the head entry and hold stable while mem_wr=1 and mem_ack=0.
//  - Latency: an accepted strobe in cycle N makes mem_wr=1 in cycle N+1 if the FIFO was empty.
//    No bypass path.
//  - wr_full = (count == DEPTH), derived from registered count. It is not affected by a same-cycle pop.
//  - Push+pop same cycle, 0 < count < DEPTH: count unchanged; both pointers advance.
//  - Push while full: rejected. Entry is not written, count is unchanged, and wr_ovf is set to 1 the next cycle.
//    wr_ovf stays set until reset. A pop in the same cycle does not rescue the push.
//  - mem_ack while mem_wr=0: ignored.
//  - count width is clog2(DEPTH)+1 and never exceeds DEPTH or drops below 0.
// CONFIGURATION
//  BLIT_WR_MERGE_EN defined:
//   - Stored data byte n = be[n] ? srcd byte n : dstd byte n.
//   - Stored mem_be = 8'hFF (full-phrase read-modify-write). Drop rules are unchanged: be==0 still drops.
//  BLIT_WR_MERGE_EN undefined:
//   - Stored data = srcd and stored mem_be = be.
//   - The dstd port is present but unused.
// TESTING
//  1. Reset, then wr_stb with waddr=0x12345, srcd=64'h0123456789ABCDEF, dbinh_n=8'hFF, emask=8'h0F, mem_ack=0
//     -> next cycle mem_wr=1, mem_addr=0x12345, mem_be=8'h0F, and the outputs hold until mem_ack.
//  2. Strobe with nowrite=1, or with dbinh_n=8'hF0 & emask=8'h0F
//     -> mem_wr stays 0, count stays 0, wr_ovf stays 0.
//  3. DEPTH=2, mem_ack=0, three strobes in consecutive cycles
//     -> wr_full=1 after the 2nd; the 3rd is rejected and wr_ovf=1.
//     Then ack twice -> entries 1 and 2 come out in order, then mem_wr=0 and wr_full=0.
//  4. count=1 with mem_ack=1 and wr_stb in the same cycle
//     -> count stays 1, the new entry is at the head next cycle, no loss or duplicate.
//     Run 8 such cycles to exercise pointer wrap.
//  5. BLIT_WR_MERGE_EN defined, srcd=64'hAAAA..., dstd=64'h5555..., be=8'h81
//     -> mem_data=64'hAA5555555555 55AA (bytes 7 and 0 from srcd), mem_be=8'hFF.
//  6. Reset asserted while count=2 and mem_ack=1
//     -> next cycle count=0, mem_wr=0, wr_full=0, wr_ovf=0.

Source files
------------

// File: rtl/blit_wr_buf.sv
// Blitter destination write stage: per-byte enables, phrase FIFO, valid/ack memory port.
// Optional build macro BLIT_WR_MERGE_EN selects full-phrase read-modify-write data merging.
module blit_wr_buf #(
    parameter int unsigned AW    = 21,
    parameter int unsigned DEPTH = 2
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          wr_stb,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   srcd,
    input  logic [63:0]   dstd,
    input  logic [7:0]    emask,
    input  logic [7:0]    dbinh_n,
    input  logic          nowrite,
    output logic          wr_full,
    output logic          wr_ovf,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [63:0]   mem_data,
    output logic [7:0]    mem_be,
    input  logic          mem_ack
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [63:0]   data_mem [DEPTH];
    logic [7:0]    be_mem   [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    be;
    logic [63:0]   store_data;
    logic [7:0]    store_be;
    logic          wr_req, push, pop, ovf_evt;

    assign be      = dbinh_n & emask;
    // A strobe that would write nothing is dropped before it can touch the FIFO.
    assign wr_req  = wr_stb & ~nowrite & (be != 8'h00);
    assign wr_full = (count == FullCount);
    assign push    = wr_req & ~wr_full;
    assign ovf_evt = wr_req & wr_full;
    assign mem_wr  = (count != '0);
    assign pop     = mem_wr & mem_ack;

    always_comb begin
        store_data = srcd;
        store_be   = be;
`ifdef BLIT_WR_MERGE_EN
        for (int n = 0; n < 8; n++) begin
            store_data[8*n +: 8] = be[n] ? srcd[8*n +: 8] : dstd[8*n +: 8];
        end
        store_be = 8'hFF;
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            wr_ovf <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (ovf_evt) wr_ovf <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while count is non-zero.
    always_ff @(posedge sys_clk) begin
        if (push && !reset) begin
            addr_mem[wr_ptr] <= waddr;
            data_mem[wr_ptr] <= store_data;
            be_mem[wr_ptr]   <= store_be;
        end
    end

    assign mem_addr = mem_wr ? addr_mem[rd_ptr] : '0;
    assign mem_data = mem_wr ? data_mem[rd_ptr] : '0;
    assign mem_be   = mem_wr ? be_mem[rd_ptr]   : '0;

`ifndef BLIT_WR_MERGE_EN
    logic unused_dstd;
    assign unused_dstd = ^dstd;
`endif

endmodule
